// File: rtl/segled_shift_ctrl.sv
// Sequencer for the serial seven-segment chain: encodes 8 hex digits (with
// dot/blank masks) into a 64-bit frame and shifts it out MSB first, with a
// one-entry pending buffer so the core may request updates at any time.
module segled_shift_ctrl #(
  parameter int unsigned DIV             = 2,
  parameter int unsigned INIT_CLR_CYCLES = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] data,
  input  logic [7:0]  dot_en,
  input  logic [7:0]  blank,
  input  logic        load,
  output logic        busy,
  output logic        done,
  output logic        SEGLED_CLK,
  output logic        SEGLED_DO,
  output logic        SEGLED_PEN,
  output logic        SEGLED_CLR
);

  localparam int unsigned DW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int unsigned IW = (INIT_CLR_CYCLES > 1) ? $clog2(INIT_CLR_CYCLES) : 1;

  typedef enum logic [1:0] {
    S_INIT,
    S_IDLE,
    S_SHIFT,
    S_DONE
  } state_t;

  state_t        state_q, state_d;
  logic [DW-1:0] div_q, div_d;
  logic          phase_q, phase_d;
  logic [5:0]    bit_q, bit_d;
  logic [63:0]   frame_q, frame_d;
  logic [IW-1:0] init_q, init_d;
  logic          pend_q, pend_d;
  logic [31:0]   pdata_q, pdata_d;
  logic [7:0]    pdot_q, pdot_d;
  logic [7:0]    pblank_q, pblank_d;

  logic          take_load;
  logic          take_pend;

  // Active-low segment byte {p,g,f,e,d,c,b,a} for one digit.
  function automatic logic [7:0] seg_byte(input logic [3:0] h, input logic dp,
                                          input logic blk);
    logic [7:0] s;
    case (h)
      4'h0: s = 8'hC0;
      4'h1: s = 8'hF9;
      4'h2: s = 8'hA4;
      4'h3: s = 8'hB0;
      4'h4: s = 8'h99;
      4'h5: s = 8'h92;
      4'h6: s = 8'h82;
      4'h7: s = 8'hF8;
      4'h8: s = 8'h80;
      4'h9: s = 8'h90;
      4'hA: s = 8'h88;
      4'hB: s = 8'h83;
      4'hC: s = 8'hC6;
      4'hD: s = 8'hA1;
      4'hE: s = 8'h86;
      default: s = 8'h8E;
    endcase
    if (dp) s[7] = 1'b0;
    if (blk) s = '1;
    return s;
  endfunction

  // Full frame, byte7 in the top bits so it leaves first.
  function automatic logic [63:0] encode(input logic [31:0] d, input logic [7:0] dp,
                                         input logic [7:0] blk);
    logic [63:0] f;
    f = '0;
    for (int unsigned i = 0; i < 8; i++) begin
      f[i*8 +: 8] = seg_byte(d[i*4 +: 4], dp[i], blk[i]);
    end
    return f;
  endfunction

  // State and datapath registers; reset discards any partial frame and pending entry.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= S_INIT;
      div_q    <= '0;
      phase_q  <= 1'b0;
      bit_q    <= '0;
      frame_q  <= '0;
      init_q   <= '0;
      pend_q   <= 1'b0;
      pdata_q  <= '0;
      pdot_q   <= '0;
      pblank_q <= '0;
    end else begin
      state_q  <= state_d;
      div_q    <= div_d;
      phase_q  <= phase_d;
      bit_q    <= bit_d;
      frame_q  <= frame_d;
      init_q   <= init_d;
      pend_q   <= pend_d;
      pdata_q  <= pdata_d;
      pdot_q   <= pdot_d;
      pblank_q <= pblank_d;
    end
  end

  // Next-state logic: init hold, frame start, bit/phase sequencing, pending buffer.
  always_comb begin
    state_d   = state_q;
    div_d     = div_q;
    phase_d   = phase_q;
    bit_d     = bit_q;
    frame_d   = frame_q;
    init_d    = init_q;
    pend_d    = pend_q;
    pdata_d   = pdata_q;
    pdot_d    = pdot_q;
    pblank_d  = pblank_q;
    take_load = 1'b0;
    take_pend = 1'b0;

    case (state_q)
      S_INIT: begin
        if (init_q == IW'(INIT_CLR_CYCLES - 1)) begin
          state_d = S_IDLE;
        end else begin
          init_d = init_q + IW'(1);
        end
      end
      S_IDLE: begin
        if (load) begin
          take_load = 1'b1;
        end else if (pend_q) begin
          take_pend = 1'b1;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_SHIFT: begin
        if (div_q == DW'(DIV - 1)) begin
          div_d = '0;
          if (phase_q) begin
            phase_d = 1'b0;
            frame_d = {frame_q[62:0], 1'b0};
            if (bit_q == 6'd63) begin
              state_d = S_DONE;
              bit_d   = '0;
            end else begin
              bit_d = bit_q + 6'd1;
            end
          end else begin
            phase_d = 1'b1;
          end
        end else begin
          div_d = div_q + DW'(1);
        end
      end
      default: begin
        // DONE chains straight into a queued frame so busy returns the next cycle;
        // a load arriving in this same cycle becomes the new pending entry.
        if (pend_q) begin
          take_pend = 1'b1;
        end else begin
          state_d = S_IDLE;
        end
      end
    endcase

    if (take_load || take_pend) begin
      state_d = S_SHIFT;
      div_d   = '0;
      phase_d = 1'b0;
      bit_d   = '0;
      frame_d = take_load ? encode(data, dot_en, blank)
                          : encode(pdata_q, pdot_q, pblank_q);
    end

    if (load && !take_load) begin
      pend_d   = 1'b1;
      pdata_d  = data;
      pdot_d   = dot_en;
      pblank_d = blank;
    end else if (take_pend) begin
      pend_d = 1'b0;
    end
  end

  // Outputs decode directly from registered state, so reset forces them low at once.
  always_comb begin
    busy       = (state_q == S_SHIFT);
    done       = (state_q == S_DONE);
    SEGLED_CLK = (state_q == S_SHIFT) && phase_q;
    SEGLED_DO  = (state_q == S_SHIFT) && frame_q[63];
    SEGLED_PEN = (state_q == S_IDLE) || (state_q == S_DONE);
    SEGLED_CLR = (state_q != S_INIT);
  end

endmodule

// File: tb/tb_segled_shift_ctrl.sv
// Scoreboard bench: one instance with DIV=2 and one with DIV=1, both with a
// 4-cycle clear hold. Expected frames are queued when loads are driven and
// checked against the serial stream when done pulses.
module tb_segled_shift_ctrl;

  logic        clk;
  logic        reset;
  logic [31:0] data;
  logic [7:0]  dot_en;
  logic [7:0]  blank;
  logic [1:0]  load_w, busy_w, done_w, sclk_w, sdo_w, pen_w, clr_w;

  int unsigned n_tests;
  int unsigned n_fail;
  int unsigned cyc;

  typedef struct {
    int unsigned g;
    logic [63:0] f;
    int unsigned le;
  } item_t;

  item_t       exp_q[$];
  logic [63:0] pend_f[2];
  logic        pend_v[2];
  logic        inflight[2];

  logic [63:0] shreg[2];
  int unsigned nbits[2], run[2], perr[2], done_cnt[2], busy_cnt[2];
  logic        prev[2], bprev[2];

  logic [7:0] seg_tab[16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                              8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};

  segled_shift_ctrl #(.DIV(2), .INIT_CLR_CYCLES(4)) u_dut (
    .clk(clk), .reset(reset), .data(data), .dot_en(dot_en), .blank(blank),
    .load(load_w[0]), .busy(busy_w[0]), .done(done_w[0]),
    .SEGLED_CLK(sclk_w[0]), .SEGLED_DO(sdo_w[0]),
    .SEGLED_PEN(pen_w[0]), .SEGLED_CLR(clr_w[0])
  );

  segled_shift_ctrl #(.DIV(1), .INIT_CLR_CYCLES(4)) u_dut1 (
    .clk(clk), .reset(reset), .data(data), .dot_en(dot_en), .blank(blank),
    .load(load_w[1]), .busy(busy_w[1]), .done(done_w[1]),
    .SEGLED_CLK(sclk_w[1]), .SEGLED_DO(sdo_w[1]),
    .SEGLED_PEN(pen_w[1]), .SEGLED_CLR(clr_w[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic int unsigned div_of(input int unsigned g);
    return (g == 0) ? 2 : 1;
  endfunction

  function automatic logic [63:0] model_frame(input logic [31:0] d, input logic [7:0] dp,
                                              input logic [7:0] bl);
    logic [63:0] f;
    logic [7:0]  b;
    logic [3:0]  nib;
    f = '0;
    for (int i = 7; i >= 0; i--) begin
      nib = d[i*4 +: 4];
      b   = seg_tab[nib];
      if (dp[i]) b = b & 8'h7F;
      if (bl[i]) b = 8'hFF;
      f = {f[55:0], b};
    end
    return f;
  endfunction

  // Monitor for both instances: capture bits on SEGLED_CLK rising, check
  // phase lengths and PEN during shift, and score each completed frame.
  always @(negedge clk) begin
    item_t it;
    for (int g = 0; g < 2; g++) begin
      if (reset) begin
        nbits[g] = 0;
        perr[g]  = 0;
        run[g]   = 0;
        prev[g]  = 1'b0;
        bprev[g] = 1'b0;
        shreg[g] = '0;
      end else begin
        if (busy_w[g]) begin
          busy_cnt[g]++;
          if (!bprev[g]) run[g] = 1;
          else if (sclk_w[g] == prev[g]) run[g]++;
          else begin
            if (run[g] != div_of(g)) perr[g]++;
            run[g] = 1;
          end
          if (sclk_w[g] && !prev[g]) begin
            shreg[g] = {shreg[g][62:0], sdo_w[g]};
            nbits[g]++;
          end
          if (pen_w[g]) perr[g]++;
        end
        if (done_w[g]) begin
          done_cnt[g]++;
          check("final_run", 64'(run[g]), 64'(div_of(g)));
          check("pen_done", 64'(pen_w[g]), 64'd1);
          if (exp_q.size() == 0) begin
            check("spurious_done", 64'd1, 64'd0);
          end else begin
            it = exp_q.pop_front();
            check("done_inst", 64'(g), 64'(it.g));
            check("frame", shreg[g], it.f);
            check("nbits", 64'(nbits[g]), 64'd64);
            check("phase_err", 64'(perr[g]), 64'd0);
            check("latency", 64'(cyc - it.le), 64'(128 * div_of(g)));
          end
          if (pend_v[g]) begin
            it.g  = g;
            it.f  = pend_f[g];
            it.le = cyc + 1;
            exp_q.push_back(it);
            pend_v[g] = 1'b0;
          end else begin
            inflight[g] = 1'b0;
          end
          nbits[g] = 0;
          perr[g]  = 0;
          shreg[g] = '0;
        end
        prev[g]  = sclk_w[g];
        bprev[g] = busy_w[g];
      end
    end
  end

  task automatic do_load(input int g, input logic [31:0] d, input logic [7:0] dp,
                         input logic [7:0] bl);
    item_t it;
    @(negedge clk);
    data   = d;
    dot_en = dp;
    blank  = bl;
    load_w[g] = 1'b1;
    if (inflight[g]) begin
      pend_f[g] = model_frame(d, dp, bl);
      pend_v[g] = 1'b1;
    end else begin
      it.g  = g;
      it.f  = model_frame(d, dp, bl);
      it.le = cyc + 1;
      exp_q.push_back(it);
      inflight[g] = 1'b1;
    end
    @(negedge clk);
    load_w[g] = 1'b0;
  endtask

  task automatic wait_idle(input int unsigned budget);
    int unsigned n;
    n = 0;
    while ((exp_q.size() != 0 || busy_w != 2'b00) && n < budget) begin
      @(negedge clk);
      n++;
    end
    check("timeout", 64'(n >= budget), 64'd0);
  endtask

  initial begin
    int unsigned dc0, bc0, n;
    n_tests = 0;
    n_fail  = 0;
    cyc     = 0;
    for (int g = 0; g < 2; g++) begin
      pend_v[g] = 1'b0; inflight[g] = 1'b0; done_cnt[g] = 0; busy_cnt[g] = 0;
      nbits[g] = 0; perr[g] = 0; run[g] = 0; prev[g] = 1'b0; bprev[g] = 1'b0;
      shreg[g] = '0;
    end
    data = '0; dot_en = '0; blank = '0; load_w = '0;
    reset = 1'b1;
    #1;
    check("reset_outs0", {58'd0, busy_w[0], done_w[0], sclk_w[0], sdo_w[0], pen_w[0], clr_w[0]}, 64'd0);
    check("reset_outs1", {58'd0, busy_w[1], done_w[1], sclk_w[1], sdo_w[1], pen_w[1], clr_w[1]}, 64'd0);
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    check("clr_hold", 64'(clr_w), 64'd0);
    check("pen_init", 64'(pen_w), 64'd0);
    @(negedge clk);
    check("clr_release", 64'(clr_w), 64'h3);
    check("pen_idle", 64'(pen_w), 64'h3);
    check("busy_idle", 64'(busy_w), 64'd0);

    // Single frame at DIV=2, then dot/blank masks.
    do_load(0, 32'h0123_4567, 8'h00, 8'h00);
    wait_idle(400);
    do_load(0, 32'hFFFF_FFFF, 8'h01, 8'h80);
    wait_idle(400);

    // DIV=1 instance.
    do_load(1, 32'h0123_4567, 8'h00, 8'h00);
    wait_idle(200);
    do_load(1, 32'h89AB_CDEF, 8'hA5, 8'h18);
    wait_idle(200);

    // Pending: B is overwritten by C; only A and C are shifted.
    dc0 = done_cnt[0];
    do_load(0, 32'hDEAD_BEEF, 8'h0F, 8'h00);
    repeat (10) @(negedge clk);
    do_load(0, 32'h1111_2222, 8'h00, 8'h00);
    repeat (20) @(negedge clk);
    do_load(0, 32'hCAFE_0042, 8'hF0, 8'h02);
    wait_idle(800);
    repeat (5) @(negedge clk);
    check("pend_dones", 64'(done_cnt[0] - dc0), 64'd2);

    // Reset mid-shift with a pending entry queued; nothing may follow.
    do_load(0, 32'h7654_3210, 8'h00, 8'h00);
    do_load(0, 32'hABCD_0123, 8'h00, 8'h00);
    n = 0;
    while (nbits[0] < 30 && n < 400) begin
      @(negedge clk);
      n++;
    end
    check("reach_bit30", 64'(nbits[0]), 64'd30);
    #1 reset = 1'b1;
    #1;
    check("midrst_outs", {58'd0, busy_w[0], done_w[0], sclk_w[0], sdo_w[0], pen_w[0], clr_w[0]}, 64'd0);
    exp_q.delete();
    for (int g = 0; g < 2; g++) begin
      pend_v[g] = 1'b0;
      inflight[g] = 1'b0;
    end
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (4) @(negedge clk);
    check("clr_rerun", 64'(clr_w), 64'h3);
    dc0 = done_cnt[0];
    bc0 = busy_cnt[0];
    repeat (300) @(negedge clk);
    check("no_frame_busy", 64'(busy_cnt[0] - bc0), 64'd0);
    check("no_frame_done", 64'(done_cnt[0] - dc0), 64'd0);

    // Load still works after a mid-shift reset.
    do_load(0, 32'h0F0F_A5A5, 8'h81, 8'h00);
    wait_idle(400);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
